// File: rtl/ramfifo_ctl.sv
// ramfifo_ctl: single-clock FIFO controller around an external two-port RAM.
// Words are written straight into the RAM; reads are issued ahead of demand
// and their registered data is collected in a 2-entry output buffer, which
// presents a first-word-fall-through valid/ready pop interface.
module ramfifo_ctl #(
    parameter int ADDRBIT = 9,
    parameter int DEPTH   = 512,
    parameter int WIDTH   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               push_vld,
    input  logic [WIDTH-1:0]   push_dat,
    output logic               push_rdy,
    output logic               pop_vld,
    output logic [WIDTH-1:0]   pop_dat,
    input  logic               pop_rdy,
    output logic [ADDRBIT+1:0] cnt,
    output logic [ADDRBIT-1:0] ram_wa,
    output logic               ram_we,
    output logic [WIDTH-1:0]   ram_wdi,
    output logic [ADDRBIT-1:0] ram_ra,
    output logic               ram_re,
    input  logic [WIDTH-1:0]   ram_rdo,
    output logic               ram_test,
    output logic               ram_mask
);

    localparam logic [ADDRBIT:0]   MCNT_FULL = (ADDRBIT+1)'(DEPTH);
    localparam logic [ADDRBIT:0]   MCNT_ONE  = (ADDRBIT+1)'(1);
    localparam logic [ADDRBIT-1:0] PTR_LAST  = ADDRBIT'(DEPTH - 1);
    localparam logic [ADDRBIT-1:0] PTR_ONE   = ADDRBIT'(1);

    // RAM pointers, count of words in RAM not yet read-issued, read-in-flight flag
    logic [ADDRBIT-1:0] wp_reg, wp_next;
    logic [ADDRBIT-1:0] rp_reg, rp_next;
    logic [ADDRBIT:0]   mcnt_reg, mcnt_next;
    logic               infl_reg, infl_next;

    // Output buffer: slot 0 is the head of the queue
    logic [WIDTH-1:0]   ob0_reg, ob0_next;
    logic [WIDTH-1:0]   ob1_reg, ob1_next;
    logic [1:0]         obn_reg, obn_next;

    logic               pop_take;
    logic               pop_shift;
    logic               load;
    logic [1:0]         obn_base;
    logic [2:0]         ob_demand;
    logic [2:0]         ob_limit;

    assign ram_test = 1'b0;
    assign ram_mask = 1'b0;

    assign pop_vld  = (obn_reg != 2'd0);
    assign pop_dat  = ob0_reg;
    assign pop_take = pop_vld & pop_rdy;

    assign push_rdy = ~rst & ~flush & (mcnt_reg < MCNT_FULL);
    assign ram_we   = push_vld & push_rdy;
    assign ram_wa   = wp_reg;
    assign ram_wdi  = push_dat;

    // A read may be issued only if its data will find a free buffer slot,
    // counting the word already in flight and the pop happening this cycle.
    assign ob_demand = {1'b0, obn_reg} + {2'b00, infl_reg};
    assign ob_limit  = 3'd2 + {2'b00, pop_take};
    assign ram_re    = ~flush & (mcnt_reg != '0) & (ob_demand < ob_limit);
    assign ram_ra    = rp_reg;

    assign cnt = {1'b0, mcnt_reg}
               + {{(ADDRBIT+1){1'b0}}, infl_reg}
               + {{ADDRBIT{1'b0}}, obn_reg};

    // Next-state for pointers, RAM word count and the in-flight flag
    always_comb begin
        wp_next   = wp_reg;
        rp_next   = rp_reg;
        mcnt_next = mcnt_reg;
        infl_next = ram_re;
        if (ram_we) begin
            wp_next = (wp_reg == PTR_LAST) ? '0 : wp_reg + PTR_ONE;
        end
        if (ram_re) begin
            rp_next = (rp_reg == PTR_LAST) ? '0 : rp_reg + PTR_ONE;
        end
        case ({ram_we, ram_re})
            2'b10:   mcnt_next = mcnt_reg + MCNT_ONE;
            2'b01:   mcnt_next = mcnt_reg - MCNT_ONE;
            default: mcnt_next = mcnt_reg;
        endcase
        if (flush) begin
            wp_next   = '0;
            rp_next   = '0;
            mcnt_next = '0;
            infl_next = 1'b0;
        end
    end

    // Next-state for the output buffer: pop shifts slot 1 to the head, then
    // returning read data fills the first free slot.
    always_comb begin
        pop_shift = pop_take & ~flush;
        load      = infl_reg & ~flush;
        obn_base  = obn_reg - {1'b0, pop_shift};
        ob0_next  = pop_shift ? ob1_reg : ob0_reg;
        ob1_next  = ob1_reg;
        if (load) begin
            if (obn_base == 2'd0) begin
                ob0_next = ram_rdo;
            end else begin
                ob1_next = ram_rdo;
            end
        end
        obn_next = flush ? 2'd0 : obn_base + {1'b0, load};
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_reg   <= '0;
            rp_reg   <= '0;
            mcnt_reg <= '0;
            infl_reg <= 1'b0;
            ob0_reg  <= '0;
            ob1_reg  <= '0;
            obn_reg  <= 2'd0;
        end else begin
            wp_reg   <= wp_next;
            rp_reg   <= rp_next;
            mcnt_reg <= mcnt_next;
            infl_reg <= infl_next;
            ob0_reg  <= ob0_next;
            ob1_reg  <= ob1_next;
            obn_reg  <= obn_next;
        end
    end

endmodule

// File: tb/tb_ramfifo_ctl.sv
// Bench for ramfifo_ctl with a small non-power-of-two depth and a RAM model.
module tb_ramfifo_ctl;

    localparam int ADDRBIT = 3;
    localparam int DEPTH   = 5;
    localparam int WIDTH   = 32;

    logic               clk;
    logic               rst;
    logic               flush;
    logic               push_vld;
    logic [WIDTH-1:0]   push_dat;
    logic               push_rdy;
    logic               pop_vld;
    logic [WIDTH-1:0]   pop_dat;
    logic               pop_rdy;
    logic [ADDRBIT+1:0] cnt;
    logic [ADDRBIT-1:0] ram_wa;
    logic               ram_we;
    logic [WIDTH-1:0]   ram_wdi;
    logic [ADDRBIT-1:0] ram_ra;
    logic               ram_re;
    logic [WIDTH-1:0]   ram_rdo;
    logic               ram_test;
    logic               ram_mask;

    int checks = 0;
    int errors = 0;

    ramfifo_ctl #(.ADDRBIT(ADDRBIT), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .push_vld(push_vld), .push_dat(push_dat), .push_rdy(push_rdy),
        .pop_vld(pop_vld), .pop_dat(pop_dat), .pop_rdy(pop_rdy),
        .cnt(cnt),
        .ram_wa(ram_wa), .ram_we(ram_we), .ram_wdi(ram_wdi),
        .ram_ra(ram_ra), .ram_re(ram_re), .ram_rdo(ram_rdo),
        .ram_test(ram_test), .ram_mask(ram_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-port RAM with registered read; a same-address collision returns garbage
    logic [WIDTH-1:0] mem [0:(1<<ADDRBIT)-1];
    always @(posedge clk) begin
        if (ram_re) ram_rdo <= (ram_we && ram_wa == ram_ra) ? 32'hDEAD_BEEF : mem[ram_ra];
        if (ram_we) mem[ram_wa] <= ram_wdi;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: the queue contents, how long the current head has been
    // the head, and the number of RAM writes/reads since the last clear.
    logic [WIDTH-1:0] mq[$];
    int  head_age;
    int  wr_n;
    int  rd_n;
    bit  c_push, c_pop, c_flush, c_read, was_empty;
    logic [WIDTH-1:0] c_dat;

    initial begin
        head_age = 0; wr_n = 0; rd_n = 0;
        forever begin
            @(negedge clk);
            c_push = 0; c_pop = 0; c_flush = 0; c_read = 0; c_dat = '0;
            if (!rst) begin
                chk("cnt", 64'(cnt), 64'(mq.size()));
                if (mq.size() == 0) chk("pop_vld_empty", 64'(pop_vld), 64'(0));
                else if (head_age >= 2) chk("pop_vld_ready", 64'(pop_vld), 64'(1));
                if (pop_vld && mq.size() > 0) chk("pop_dat", 64'(pop_dat), 64'(mq[0]));
                if (flush) begin
                    chk("flush_push_rdy", 64'(push_rdy), 64'(0));
                    chk("flush_ram_we", 64'(ram_we), 64'(0));
                    chk("flush_ram_re", 64'(ram_re), 64'(0));
                end else if (mq.size() < DEPTH) begin
                    chk("push_rdy_room", 64'(push_rdy), 64'(1));
                end else if (mq.size() >= DEPTH + 2) begin
                    chk("push_rdy_full", 64'(push_rdy), 64'(0));
                end
                chk("ram_we", 64'(ram_we), 64'(push_vld & push_rdy));
                if (ram_we) begin
                    chk("ram_wdi", 64'(ram_wdi), 64'(push_dat));
                    chk("ram_wa", 64'(ram_wa), 64'(wr_n % DEPTH));
                end
                if (ram_re) chk("ram_ra", 64'(ram_ra), 64'(rd_n % DEPTH));
                chk("collision", 64'(ram_we & ram_re & (ram_wa == ram_ra)), 64'(0));
                chk("ram_tie", 64'({ram_test, ram_mask}), 64'(0));
                c_flush = flush;
                c_push  = push_vld & push_rdy & ~flush;
                c_pop   = pop_vld & pop_rdy & ~flush;
                c_read  = ram_re;
                c_dat   = push_dat;
            end
            @(posedge clk);
            if (rst || c_flush) begin
                mq.delete();
                head_age = 0; wr_n = 0; rd_n = 0;
            end else begin
                was_empty = (mq.size() == 0);
                if (c_pop && mq.size() > 0) void'(mq.pop_front());
                if (c_push) begin
                    mq.push_back(c_dat);
                    wr_n++;
                end
                if (c_read) rd_n++;
                if (mq.size() == 0 || c_pop || was_empty) head_age = 0;
                else head_age++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pop_vld"}, 64'(pop_vld), 64'(0));
        chk({tag, "_push_rdy"}, 64'(push_rdy), 64'(0));
        chk({tag, "_ram_we"}, 64'(ram_we), 64'(0));
        chk({tag, "_ram_re"}, 64'(ram_re), 64'(0));
        chk({tag, "_cnt"}, 64'(cnt), 64'(0));
        chk({tag, "_pop_dat"}, 64'(pop_dat), 64'(0));
    endtask

    int acc;

    task automatic random_traffic(input int ncycles, input int push_pct, input int pop_pct, input bit do_flush);
        for (int c = 0; c < ncycles; c++) begin
            push_vld = ($urandom_range(0, 99) < push_pct);
            push_dat = $urandom;
            pop_rdy  = ($urandom_range(0, 99) < pop_pct);
            flush    = do_flush && ($urandom_range(0, 199) == 0);
            @(negedge clk);
            if (push_vld && push_rdy) acc++;
            step();
        end
        flush = 1'b0;
    endtask

    task automatic drain(input string tag);
        push_vld = 1'b0;
        flush    = 1'b0;
        pop_rdy  = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (cnt == '0) break;
            step();
        end
        chk({tag, "_drain_cnt"}, 64'(cnt), 64'(0));
        step();
        pop_rdy = 1'b0;
    endtask

    logic [WIDTH-1:0] got[$];
    bit seen;

    initial begin
        rst = 1'b1; flush = 1'b0; push_vld = 1'b1; push_dat = 32'h1234_5678; pop_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        push_vld = 1'b0;
        rst = 1'b0;
        #1;
        chk("post_reset_push_rdy", 64'(push_rdy), 64'(1));

        // Single word latency through an empty queue
        push_vld = 1'b1; push_dat = 32'hA5A5_A5A5;
        step();
        push_vld = 1'b0;
        @(negedge clk);
        chk("lat_n1_cnt", 64'(cnt), 64'(1));
        chk("lat_n1_ram_re", 64'(ram_re), 64'(1));
        chk("lat_n1_pop_vld", 64'(pop_vld), 64'(0));
        step();
        @(negedge clk);
        chk("lat_n2_cnt", 64'(cnt), 64'(1));
        chk("lat_n2_pop_vld", 64'(pop_vld), 64'(0));
        step();
        pop_rdy = 1'b1;
        @(negedge clk);
        chk("lat_n3_pop_vld", 64'(pop_vld), 64'(1));
        chk("lat_n3_pop_dat", 64'(pop_dat), 64'h0000_0000_A5A5_A5A5);
        chk("lat_n3_cnt", 64'(cnt), 64'(1));
        step();
        pop_rdy = 1'b0;
        @(negedge clk);
        chk("lat_pop_cnt", 64'(cnt), 64'(0));
        chk("lat_pop_vld", 64'(pop_vld), 64'(0));
        step();

        // Fill to capacity DEPTH+2 with the consumer stalled, then drain in order
        acc = 0;
        for (int i = 1; i <= 10; i++) begin
            push_vld = 1'b1; push_dat = i;
            @(negedge clk);
            if (push_rdy) acc++;
            step();
        end
        push_vld = 1'b0;
        @(negedge clk);
        chk("full_accepted", 64'(acc), 64'(7));
        chk("full_cnt", 64'(cnt), 64'(7));
        chk("full_push_rdy", 64'(push_rdy), 64'(0));
        step();
        pop_rdy = 1'b1;
        got.delete();
        for (int c = 0; c < 40 && got.size() < 7; c++) begin
            @(negedge clk);
            if (pop_vld) got.push_back(pop_dat);
            step();
        end
        pop_rdy = 1'b0;
        chk("full_popped", 64'(got.size()), 64'(7));
        for (int k = 0; k < got.size(); k++) chk("full_order", 64'(got[k]), 64'(k + 1));
        @(negedge clk);
        chk("full_empty_cnt", 64'(cnt), 64'(0));
        step();

        // Streaming: push and pop every cycle from empty
        push_vld = 1'b1; pop_rdy = 1'b1;
        for (int c = 0; c < 30; c++) begin
            push_dat = $urandom;
            @(negedge clk);
            if (c >= 3) begin
                chk("stream_pop_vld", 64'(pop_vld), 64'(1));
                chk("stream_cnt", 64'(cnt), 64'(3));
            end
            step();
        end
        drain("stream");

        // Flush with a read in flight and one word buffered
        pop_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_vld = 1'b1; push_dat = 32'h100 + i;
            step();
        end
        push_vld = 1'b1; push_dat = 32'h0BAD; pop_rdy = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("flush1_pre_cnt", 64'(cnt), 64'(3));
        chk("flush1_pre_pop_vld", 64'(pop_vld), 64'(1));
        step();
        flush = 1'b0; push_vld = 1'b0; pop_rdy = 1'b0;
        @(negedge clk);
        chk("flush1_cnt", 64'(cnt), 64'(0));
        chk("flush1_pop_vld", 64'(pop_vld), 64'(0));
        step();
        @(negedge clk);
        chk("flush1_stale_cnt", 64'(cnt), 64'(0));
        chk("flush1_stale_pop_vld", 64'(pop_vld), 64'(0));
        step();
        push_vld = 1'b1; push_dat = 32'h1;
        step();
        push_vld = 1'b0; pop_rdy = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (pop_vld) begin
                seen = 1'b1;
                chk("flush1_after_dat", 64'(pop_dat), 64'(1));
            end
            step();
        end
        chk("flush1_after_seen", 64'(seen), 64'(1));
        pop_rdy = 1'b0;

        // Flush with a full output buffer
        for (int i = 0; i < 4; i++) begin
            push_vld = 1'b1; push_dat = 32'h200 + i;
            step();
        end
        push_vld = 1'b0;
        repeat (3) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("flush2_cnt", 64'(cnt), 64'(0));
        chk("flush2_pop_vld", 64'(pop_vld), 64'(0));
        step();

        // Random traffic: 1000 accepted words, random stalls and rare flushes
        acc = 0;
        for (int blk = 0; blk < 60 && acc < 1000; blk++) random_traffic(100, 70, 60, 1'b1);
        chk("random_accepted", 64'(acc >= 1000), 64'(1));
        drain("random");

        // Asynchronous reset in the middle of traffic
        acc = 0;
        random_traffic(20, 90, 20, 1'b0);
        push_vld = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("async");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_vld = 1'b0;
        random_traffic(300, 60, 60, 1'b0);
        chk("restart_traffic", 64'(acc > 20), 64'(1));
        drain("restart");

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
